// File: rtl/mor1kx_ctrl_wb_cappuccino.sv
// mor1kx_ctrl_wb_cappuccino
//   Control-to-writeback stage of the cappuccino pipeline. It tracks
//   outstanding load/mfspr completion, aligns and extends big-endian load
//   data, selects the writeback result and issues one register-file write
//   pulse per retiring instruction, together with the writeback PC.
//
//   Optional feature: define OR1K_WB_RETIRE_COUNT_EN to add a 32-bit retire
//   counter (wb_retire_cnt_o) and a retire strobe (wb_retire_o).
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   padv_ctrl_i          ctrl stage advances this cycle
//   pipeline_flush_i     kills the in-flight ctrl instruction
//   ctrl_*_i             decoded ctrl-stage instruction fields
//   lsu_dat_i/lsu_valid_i        load data bus and single-cycle valid
//   mfspr_dat_i/ctrl_mfspr_ack_i SPR read data and single-cycle ack
//   pc_ctrl_i            ctrl-stage PC
//   wb_rf_wb_o           RF write enable (one-cycle pulse)
//   wb_rfd_adr_o         RF write address
//   wb_result_o          RF write data
//   pc_wb_o              PC of the last retired instruction
//   wb_busy_o            load/mfspr outstanding
//   wb_retire_cnt_o      retired instruction count (optional)
//   wb_retire_o          retire strobe (optional)

`ifndef OR1K_RESET_VECTOR
`define OR1K_RESET_VECTOR 5'h01
`endif

// state | meaning
// IDLE  | no load/mfspr pending; ALU results retire on padv_ctrl_i
// WAIT  | load/mfspr issued, waiting for lsu_valid_i / ctrl_mfspr_ack_i
// DONE  | load/mfspr result written, holding until ctrl advances
module mor1kx_ctrl_wb_cappuccino #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter logic [OPTION_OPERAND_WIDTH-1:0] OPTION_RESET_PC =
    {{(OPTION_OPERAND_WIDTH-13){1'b0}}, `OR1K_RESET_VECTOR, 8'd0}
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            padv_ctrl_i,
  input  logic                            pipeline_flush_i,
  input  logic                            ctrl_bubble_i,
  input  logic                            ctrl_op_lsu_load_i,
  input  logic                            ctrl_op_mfspr_i,
  input  logic                            ctrl_rf_wb_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] ctrl_rfd_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_alu_result_i,
  input  logic [1:0]                      ctrl_lsu_adr_i,
  input  logic [1:0]                      ctrl_lsu_length_i,
  input  logic                            ctrl_lsu_zext_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] lsu_dat_i,
  input  logic                            lsu_valid_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] mfspr_dat_i,
  input  logic                            ctrl_mfspr_ack_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] pc_ctrl_i,
  output logic                            wb_rf_wb_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] wb_result_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] pc_wb_o,
  output logic                            wb_busy_o
`ifdef OR1K_WB_RETIRE_COUNT_EN
  ,
  output logic [31:0]                     wb_retire_cnt_o,
  output logic                            wb_retire_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state;

  logic [7:0]                      byte_sel;
  logic [15:0]                     half_sel;
  logic [OPTION_OPERAND_WIDTH-1:0] load_data;
  logic [OPTION_OPERAND_WIDTH-1:0] acc_data;
  logic [OPTION_OPERAND_WIDTH-1:0] cap_data;
  logic                            ctrl_is_acc;
  logic                            acc_complete;
  logic                            acc_fire;
  logic                            alu_fire;
  logic                            capture_ev;

  // Big-endian lane selection; byte 0 of the word sits in bits [31:24].
  always_comb begin
    byte_sel = 8'h00;
    case (ctrl_lsu_adr_i)
      2'b00:   byte_sel = lsu_dat_i[31:24];
      2'b01:   byte_sel = lsu_dat_i[23:16];
      2'b10:   byte_sel = lsu_dat_i[15:8];
      default: byte_sel = lsu_dat_i[7:0];
    endcase
    half_sel = ctrl_lsu_adr_i[1] ? lsu_dat_i[15:0] : lsu_dat_i[31:16];
  end

  always_comb begin
    load_data = lsu_dat_i;
    case (ctrl_lsu_length_i)
      2'b00: load_data = ctrl_lsu_zext_i ?
                         {{(OPTION_OPERAND_WIDTH-8){1'b0}}, byte_sel} :
                         {{(OPTION_OPERAND_WIDTH-8){byte_sel[7]}}, byte_sel};
      2'b01: load_data = ctrl_lsu_zext_i ?
                         {{(OPTION_OPERAND_WIDTH-16){1'b0}}, half_sel} :
                         {{(OPTION_OPERAND_WIDTH-16){half_sel[15]}}, half_sel};
      // length 11 behaves as a word access
      default: load_data = lsu_dat_i;
    endcase
  end

  assign ctrl_is_acc  = !ctrl_bubble_i && (ctrl_op_lsu_load_i || ctrl_op_mfspr_i);
  assign acc_complete = (ctrl_op_lsu_load_i && lsu_valid_i) ||
                        (ctrl_op_mfspr_i && ctrl_mfspr_ack_i);
  assign acc_data     = ctrl_op_lsu_load_i ? load_data : mfspr_dat_i;

  // Completions are only honoured while an access is actually pending, so
  // stray valid/ack pulses in DONE or after a flush never reach the RF.
  assign acc_fire   = !pipeline_flush_i && acc_complete &&
                      (((state == ST_IDLE) && ctrl_is_acc) || (state == ST_WAIT));
  assign alu_fire   = !pipeline_flush_i && (state == ST_IDLE) && !ctrl_is_acc &&
                      !ctrl_bubble_i && padv_ctrl_i;
  assign capture_ev = acc_fire || alu_fire;
  assign cap_data   = alu_fire ? ctrl_alu_result_i : acc_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      wb_rf_wb_o   <= 1'b0;
      wb_rfd_adr_o <= '0;
      wb_result_o  <= '0;
      pc_wb_o      <= OPTION_RESET_PC;
      wb_busy_o    <= 1'b0;
    end else begin
      wb_rf_wb_o <= capture_ev && ctrl_rf_wb_i;
      if (capture_ev) begin
        wb_rfd_adr_o <= ctrl_rfd_adr_i;
        wb_result_o  <= cap_data;
        pc_wb_o      <= pc_ctrl_i;
      end

      if (pipeline_flush_i) begin
        state     <= ST_IDLE;
        wb_busy_o <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (ctrl_is_acc) begin
              if (acc_complete) begin
                state     <= ST_DONE;
                wb_busy_o <= 1'b0;
              end else begin
                state     <= ST_WAIT;
                wb_busy_o <= 1'b1;
              end
            end
          end
          ST_WAIT: begin
            if (acc_complete) begin
              state     <= ST_DONE;
              wb_busy_o <= 1'b0;
            end
          end
          ST_DONE: begin
            wb_busy_o <= 1'b0;
            if (padv_ctrl_i)
              state <= ST_IDLE;
          end
          default: begin
            state     <= ST_IDLE;
            wb_busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef OR1K_WB_RETIRE_COUNT_EN
  // Counts every retiring instruction, including ones that do not write the RF.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_retire_cnt_o <= 32'd0;
      wb_retire_o     <= 1'b0;
    end else begin
      wb_retire_o <= capture_ev;
      if (capture_ev)
        wb_retire_cnt_o <= wb_retire_cnt_o + 32'd1;
    end
  end
`else
  // Retire counter not built.
`endif

endmodule

// File: tb/tb_mor1kx_ctrl_wb_cappuccino.sv
module tb_mor1kx_ctrl_wb_cappuccino;

  logic        clk = 1'b0;
  logic        rst;
  logic        padv_ctrl_i, pipeline_flush_i, ctrl_bubble_i;
  logic        ctrl_op_lsu_load_i, ctrl_op_mfspr_i, ctrl_rf_wb_i;
  logic [4:0]  ctrl_rfd_adr_i;
  logic [31:0] ctrl_alu_result_i;
  logic [1:0]  ctrl_lsu_adr_i, ctrl_lsu_length_i;
  logic        ctrl_lsu_zext_i;
  logic [31:0] lsu_dat_i;
  logic        lsu_valid_i;
  logic [31:0] mfspr_dat_i;
  logic        ctrl_mfspr_ack_i;
  logic [31:0] pc_ctrl_i;
  logic        wb_rf_wb_o;
  logic [4:0]  wb_rfd_adr_o;
  logic [31:0] wb_result_o, pc_wb_o;
  logic        wb_busy_o;
`ifdef OR1K_WB_RETIRE_COUNT_EN
  logic [31:0] wb_retire_cnt_o;
  logic        wb_retire_o;
`endif

  mor1kx_ctrl_wb_cappuccino dut (
    .clk               (clk),
    .rst               (rst),
    .padv_ctrl_i       (padv_ctrl_i),
    .pipeline_flush_i  (pipeline_flush_i),
    .ctrl_bubble_i     (ctrl_bubble_i),
    .ctrl_op_lsu_load_i(ctrl_op_lsu_load_i),
    .ctrl_op_mfspr_i   (ctrl_op_mfspr_i),
    .ctrl_rf_wb_i      (ctrl_rf_wb_i),
    .ctrl_rfd_adr_i    (ctrl_rfd_adr_i),
    .ctrl_alu_result_i (ctrl_alu_result_i),
    .ctrl_lsu_adr_i    (ctrl_lsu_adr_i),
    .ctrl_lsu_length_i (ctrl_lsu_length_i),
    .ctrl_lsu_zext_i   (ctrl_lsu_zext_i),
    .lsu_dat_i         (lsu_dat_i),
    .lsu_valid_i       (lsu_valid_i),
    .mfspr_dat_i       (mfspr_dat_i),
    .ctrl_mfspr_ack_i  (ctrl_mfspr_ack_i),
    .pc_ctrl_i         (pc_ctrl_i),
    .wb_rf_wb_o        (wb_rf_wb_o),
    .wb_rfd_adr_o      (wb_rfd_adr_o),
    .wb_result_o       (wb_result_o),
    .pc_wb_o           (pc_wb_o),
    .wb_busy_o         (wb_busy_o)
`ifdef OR1K_WB_RETIRE_COUNT_EN
    ,
    .wb_retire_cnt_o   (wb_retire_cnt_o),
    .wb_retire_o       (wb_retire_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  logic [31:0] exp_result, exp_pc;
  logic [4:0]  exp_adr;
  logic [31:0] exp_cnt;

  always @(negedge clk) if (wb_rf_wb_o === 1'b1) pulses++;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    padv_ctrl_i        = 1'b0;
    pipeline_flush_i   = 1'b0;
    ctrl_bubble_i      = 1'b1;
    ctrl_op_lsu_load_i = 1'b0;
    ctrl_op_mfspr_i    = 1'b0;
    ctrl_rf_wb_i       = 1'b0;
    lsu_valid_i        = 1'b0;
    ctrl_mfspr_ack_i   = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_adr"}, {27'd0, wb_rfd_adr_o}, {27'd0, exp_adr});
    chk({tag, "_res"}, wb_result_o, exp_result);
    chk({tag, "_pc"}, pc_wb_o, exp_pc);
`ifdef OR1K_WB_RETIRE_COUNT_EN
    chk({tag, "_cnt"}, wb_retire_cnt_o, exp_cnt);
`endif
  endtask

  // Reference load extraction: shift the addressed big-endian lane down,
  // mask it, then sign-extend arithmetically when requested.
  function automatic logic [31:0] ref_load(input logic [31:0] dat, input logic [1:0] adr,
                                           input logic [1:0] len, input logic zext);
    logic [31:0] v;
    int unsigned sh;
    case (len)
      2'b00: begin
        sh = 8 * (3 - int'(adr));
        v  = (dat >> sh) & 32'h0000_00FF;
        if (!zext && v >= 32'h80) v = v - 32'h100;
      end
      2'b01: begin
        sh = adr[1] ? 0 : 16;
        v  = (dat >> sh) & 32'h0000_FFFF;
        if (!zext && v >= 32'h8000) v = v - 32'h1_0000;
      end
      default: v = dat;
    endcase
    return v;
  endfunction

  task automatic do_alu(input logic rfwb, input logic [4:0] rfd,
                        input logic [31:0] res, input logic [31:0] pc);
    int p0;
    p0 = pulses;
    ctrl_bubble_i = 1'b0; ctrl_rf_wb_i = rfwb; ctrl_rfd_adr_i = rfd;
    ctrl_alu_result_i = res; pc_ctrl_i = pc; padv_ctrl_i = 1'b1;
    lsu_valid_i = $urandom_range(0, 1); ctrl_mfspr_ack_i = $urandom_range(0, 1);
    step();
    idle_inputs();
    exp_adr = rfd; exp_result = res; exp_pc = pc; exp_cnt = exp_cnt + 1;
    chk("alu_we", {31'd0, wb_rf_wb_o}, {31'd0, rfwb});
    check_regs("alu");
    step();
    chk("alu_we_drop", {31'd0, wb_rf_wb_o}, 32'd0);
    chk("alu_pulses", 32'(pulses - p0), {31'd0, rfwb});
  endtask

  task automatic do_acc(input bit is_spr, input logic rfwb, input logic [4:0] rfd,
                        input logic [31:0] dat, input logic [1:0] adr, input logic [1:0] len,
                        input logic zext, input logic [31:0] pc, input int delay,
                        input bit spurious);
    int p0;
    p0 = pulses;
    ctrl_bubble_i = 1'b0; ctrl_op_lsu_load_i = !is_spr; ctrl_op_mfspr_i = is_spr;
    ctrl_rf_wb_i = rfwb; ctrl_rfd_adr_i = rfd; pc_ctrl_i = pc;
    ctrl_lsu_adr_i = adr; ctrl_lsu_length_i = len; ctrl_lsu_zext_i = zext;
    ctrl_alu_result_i = $urandom;
    lsu_dat_i   = is_spr ? $urandom : dat;
    mfspr_dat_i = is_spr ? dat : $urandom;
    for (int i = 0; i < delay; i++) begin
      step();
      chk("acc_busy", {31'd0, wb_busy_o}, 32'd1);
      chk("acc_we_wait", {31'd0, wb_rf_wb_o}, 32'd0);
    end
    if (is_spr) ctrl_mfspr_ack_i = 1'b1; else lsu_valid_i = 1'b1;
    step();
    lsu_valid_i = 1'b0; ctrl_mfspr_ack_i = 1'b0;
    exp_adr = rfd; exp_pc = pc; exp_cnt = exp_cnt + 1;
    exp_result = is_spr ? dat : ref_load(dat, adr, len, zext);
    chk("acc_we", {31'd0, wb_rf_wb_o}, {31'd0, rfwb});
    chk("acc_busy_done", {31'd0, wb_busy_o}, 32'd0);
    check_regs("acc");
    if (spurious) begin
      if (is_spr) ctrl_mfspr_ack_i = 1'b1; else lsu_valid_i = 1'b1;
    end
    padv_ctrl_i = 1'b1;
    step();
    idle_inputs();
    chk("acc_we_drop", {31'd0, wb_rf_wb_o}, 32'd0);
    step();
    chk("acc_pulses", 32'(pulses - p0), {31'd0, rfwb});
    check_regs("acc_hold");
  endtask

  task automatic do_bubble();
    int p0;
    p0 = pulses;
    ctrl_bubble_i = 1'b1; padv_ctrl_i = 1'b1; ctrl_rf_wb_i = 1'b1;
    pc_ctrl_i = $urandom; ctrl_alu_result_i = $urandom; ctrl_rfd_adr_i = 5'($urandom);
    ctrl_op_lsu_load_i = $urandom_range(0, 1); lsu_valid_i = 1'b1;
    step();
    idle_inputs();
    chk("bub_we", {31'd0, wb_rf_wb_o}, 32'd0);
    check_regs("bub");
    step();
    chk("bub_pulses", 32'(pulses - p0), 32'd0);
  endtask

  task automatic do_flush(input bit is_spr, input int delay);
    int p0;
    p0 = pulses;
    ctrl_bubble_i = 1'b0; ctrl_op_lsu_load_i = !is_spr; ctrl_op_mfspr_i = is_spr;
    ctrl_rf_wb_i = 1'b1; ctrl_rfd_adr_i = 5'($urandom); pc_ctrl_i = $urandom;
    ctrl_lsu_length_i = 2'b10; lsu_dat_i = $urandom; mfspr_dat_i = $urandom;
    for (int i = 0; i < delay; i++) step();
    pipeline_flush_i = 1'b1;
    if (is_spr) ctrl_mfspr_ack_i = 1'b1; else lsu_valid_i = 1'b1;
    step();
    idle_inputs();
    chk("fl_we", {31'd0, wb_rf_wb_o}, 32'd0);
    chk("fl_busy", {31'd0, wb_busy_o}, 32'd0);
    check_regs("fl");
    lsu_valid_i = 1'b1; ctrl_mfspr_ack_i = 1'b1;
    step();
    idle_inputs();
    chk("fl_late_we", {31'd0, wb_rf_wb_o}, 32'd0);
    chk("fl_late_busy", {31'd0, wb_busy_o}, 32'd0);
    step();
    chk("fl_pulses", 32'(pulses - p0), 32'd0);
    check_regs("fl_late");
  endtask

  initial begin
    int kind;
    idle_inputs();
    ctrl_rfd_adr_i = '0; ctrl_alu_result_i = '0; ctrl_lsu_adr_i = '0;
    ctrl_lsu_length_i = '0; ctrl_lsu_zext_i = 1'b0; lsu_dat_i = '0;
    mfspr_dat_i = '0; pc_ctrl_i = '0;
    rst = 1'b1;
    step(); step();
    exp_adr = '0; exp_result = '0; exp_pc = 32'h0000_0100; exp_cnt = '0;
    chk("rst_we", {31'd0, wb_rf_wb_o}, 32'd0);
    chk("rst_busy", {31'd0, wb_busy_o}, 32'd0);
    check_regs("rst");
    rst = 1'b0;
    step();

    do_alu(1'b1, 5'd3, 32'h1234_5678, 32'h0000_2000);
    do_acc(1'b0, 1'b1, 5'd7, 32'h0080_0000, 2'b01, 2'b00, 1'b0, 32'h0000_2004, 4, 1'b0);
    chk("tp_byte_sext", wb_result_o, 32'hFFFF_FF80);
    do_acc(1'b0, 1'b1, 5'd7, 32'h0080_0000, 2'b01, 2'b00, 1'b1, 32'h0000_2008, 4, 1'b0);
    chk("tp_byte_zext", wb_result_o, 32'h0000_0080);
    do_acc(1'b0, 1'b1, 5'd9, 32'h1234_ABCD, 2'b10, 2'b01, 1'b0, 32'h0000_200C, 1, 1'b0);
    chk("tp_half_sext", wb_result_o, 32'hFFFF_ABCD);
    do_acc(1'b0, 1'b1, 5'd10, 32'h1234_ABCD, 2'b00, 2'b10, 1'b0, 32'h0000_2010, 0, 1'b0);
    chk("tp_word", wb_result_o, 32'h1234_ABCD);
    do_acc(1'b1, 1'b1, 5'd11, 32'hCAFE_F00D, 2'b00, 2'b00, 1'b0, 32'h0000_2014, 2, 1'b1);
    chk("tp_mfspr", wb_result_o, 32'hCAFE_F00D);
    do_alu(1'b0, 5'd12, 32'hDEAD_BEEF, 32'h0000_2018);
    do_flush(1'b0, 2);
    do_flush(1'b0, 0);
    do_flush(1'b1, 1);
    do_bubble();

    // reset while a load is outstanding discards it
    ctrl_bubble_i = 1'b0; ctrl_op_lsu_load_i = 1'b1; ctrl_rf_wb_i = 1'b1;
    step(); step();
    chk("mid_busy", {31'd0, wb_busy_o}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    exp_adr = '0; exp_result = '0; exp_pc = 32'h0000_0100; exp_cnt = '0;
    chk("mid_rst_busy", {31'd0, wb_busy_o}, 32'd0);
    check_regs("mid_rst");
    lsu_valid_i = 1'b1;
    step();
    idle_inputs();
    chk("mid_late_we", {31'd0, wb_rf_wb_o}, 32'd0);

    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: do_alu(1'($urandom), 5'($urandom), $urandom, $urandom);
        1, 2: do_acc(1'b0, 1'($urandom), 5'($urandom), $urandom, 2'($urandom),
                     2'($urandom), 1'($urandom), $urandom, $urandom_range(0, 3),
                     1'($urandom));
        3: do_acc(1'b1, 1'($urandom), 5'($urandom), $urandom, 2'($urandom),
                  2'($urandom), 1'($urandom), $urandom, $urandom_range(0, 3),
                  1'($urandom));
        default: do_bubble();
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
